// File: rtl/port_pkg.sv
// Shared definitions for the port_pipe_n slice.
// Contents:
//   PORT_W_DEFAULT - default bits per lane
//   lane_lsb()     - bit offset of lane c within a packed multi-lane bus
package port_pkg;

    localparam int unsigned PORT_W_DEFAULT = 8;

    // Lane c of a CHANNELS*width bus lives at [lane_lsb(c, width) +: width].
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/port_pipe_n_if.sv
// Handshake/bus bundle for port_pipe_n.
// Signals:
//   flush              synchronous clear of all stages
//   in_valid/in_ready  upstream handshake; in_data lanes, in_mask per-lane pass bits
//   out_valid/out_ready downstream handshake; out_data masked head data
//   count              occupied stages
//   dummy_1/dummy_2    constant-zero outputs
// Modports: master = harness side, slave = pipeline side.
interface port_pipe_n_if
    import port_pkg::*;
#(
    parameter int unsigned WIDTH    = PORT_W_DEFAULT,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned CNT_W    = 2
);
    logic                      flush;
    logic                      in_valid;
    logic                      in_ready;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_mask;
    logic                      out_valid;
    logic                      out_ready;
    logic [CHANNELS*WIDTH-1:0] out_data;
    logic [CNT_W-1:0]          count;
    logic                      dummy_1;
    logic                      dummy_2;

    modport master (
        output flush, in_valid, in_data, in_mask, out_ready,
        input  in_ready, out_valid, out_data, count, dummy_1, dummy_2
    );

    modport slave (
        input  flush, in_valid, in_data, in_mask, out_ready,
        output in_ready, out_valid, out_data, count, dummy_1, dummy_2
    );

endinterface

// File: rtl/port_pipe_stage.sv
// One elastic pipeline stage: a valid bit plus a data word.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load_i      stage takes valid_i/data_i this edge
//   flush_i     clears the valid bit (has priority over load_i for valid)
//   valid_i     incoming valid bit
//   data_i      incoming data word
//   valid_o     stage holds a beat
//   data_o      stored data word
module port_pipe_stage #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         flush_i,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = valid_i;
            data_d  = data_i;
        end
        // Data may keep whatever was loaded; only the valid bit must clear.
        if (flush_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/port_pipe_n.sv
// Multi-lane elastic pipeline with valid/ready handshake, per-beat lane mask,
// synchronous flush and occupancy count.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   pipe_if     slave side of port_pipe_n_if (handshakes, data, mask, flush,
//               count, constant-zero dummies)
// Stage 0 is the entry, stage DEPTH-1 is the head. Stages collapse bubbles:
// a stage loads whenever it is empty or the stage ahead of it loads.
module port_pipe_n
    import port_pkg::*;
#(
    parameter int unsigned WIDTH    = PORT_W_DEFAULT,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
    input logic          clk,
    input logic          rst_n,
    port_pipe_n_if.slave pipe_if
);

    localparam int unsigned DW = CHANNELS * WIDTH;

    if (DEPTH < 1) begin : g_bad_depth
        $error("port_pipe_n: DEPTH must be at least 1");
    end
    if (WIDTH < 1 || CHANNELS < 1) begin : g_bad_shape
        $error("port_pipe_n: WIDTH and CHANNELS must be at least 1");
    end

    logic [DEPTH-1:0] stage_valid;
    logic [DW-1:0]    stage_data [DEPTH];
    logic [DEPTH-1:0] stage_vin;
    logic [DW-1:0]    stage_din  [DEPTH];
    logic [DEPTH-1:0] load;
    logic [DEPTH-1:0] valid_nxt;
    logic [DW-1:0]    in_masked;
    logic             accept;
    logic             chain;
    logic [CNT_W-1:0] count_q, count_d;

    // Mask is applied on capture so in-flight beats ignore later mask changes.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_mask
        assign in_masked[lane_lsb(c, WIDTH) +: WIDTH] =
            pipe_if.in_mask[c] ? pipe_if.in_data[lane_lsb(c, WIDTH) +: WIDTH] : '0;
    end

    // Load enables ripple back from the head.
    always_comb begin
        load  = '0;
        chain = pipe_if.out_ready;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            load[k] = ~stage_valid[k] | chain;
            chain   = load[k];
        end
    end

    assign pipe_if.in_ready = load[0] & ~pipe_if.flush;
    assign accept           = pipe_if.in_valid & pipe_if.in_ready;

    always_comb begin
        stage_vin    = '0;
        stage_vin[0] = accept;
        stage_din[0] = in_masked;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            stage_vin[k] = stage_valid[k-1];
            stage_din[k] = stage_data[k-1];
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        port_pipe_stage #(
            .W (DW)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_i  (load[k]),
            .flush_i (pipe_if.flush),
            .valid_i (stage_vin[k]),
            .data_i  (stage_din[k]),
            .valid_o (stage_valid[k]),
            .data_o  (stage_data[k])
        );
    end

    // Occupancy tracks the valid bits the stages will hold after this edge.
    always_comb begin
        count_d = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (pipe_if.flush) begin
                valid_nxt[k] = 1'b0;
            end else if (load[k]) begin
                valid_nxt[k] = stage_vin[k];
            end else begin
                valid_nxt[k] = stage_valid[k];
            end
            count_d = count_d + CNT_W'(valid_nxt[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign pipe_if.count     = count_q;
    assign pipe_if.out_valid = stage_valid[DEPTH-1];
    assign pipe_if.out_data  = stage_valid[DEPTH-1] ? stage_data[DEPTH-1] : '0;
    assign pipe_if.dummy_1   = 1'b0;
    assign pipe_if.dummy_2   = 1'b0;

endmodule

// File: tb/tb_port_pipe_n.sv
module tb_port_pipe_n;

    localparam int unsigned W  = 8;
    localparam int unsigned CH = 2;
    localparam int unsigned DP = 3;
    localparam int unsigned CW = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    port_pipe_n_if #(.WIDTH(W), .CHANNELS(CH), .CNT_W(CW)) bus ();

    port_pipe_n #(
        .WIDTH    (W),
        .CHANNELS (CH),
        .DEPTH    (DP)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .pipe_if (bus.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
        bus.in_mask = 2'b11; bus.out_ready = 1'b0;
        #12;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data got %h want 0000", bus.out_data); end
        checks++; if (bus.count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
        checks++; if ({bus.dummy_1, bus.dummy_2} !== 2'b00) begin errors++; $display("FAIL reset_dummy got %b want 00", {bus.dummy_1, bus.dummy_2}); end
        #1 rst_n = 1'b1;
        step();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_walking_one();
        logic [7:0]  b;
        logic        ev;
        logic [15:0] exp;
        bus.out_ready = 1'b1; bus.in_mask = 2'b11;
        for (int c = 0; c < 12; c++) begin
            b = 8'(1 << (c % 8));
            bus.in_valid = (c < 8);
            bus.in_data  = (c < 8) ? {b, b} : 16'h0;
            #1;
            ev = (c >= 3 && c <= 10);
            checks++; if (bus.out_valid !== ev) begin errors++; $display("FAIL walk_valid cycle %0d got %b want %b", c, bus.out_valid, ev); end
            if (ev) begin
                b   = 8'(1 << (c - 3));
                exp = {b, b};
                checks++; if (bus.out_data !== exp) begin errors++; $display("FAIL walk_data cycle %0d got %h want %h", c, bus.out_data, exp); end
            end
            if (c < 8) begin
                checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL walk_in_ready cycle %0d got %b want 1", c, bus.in_ready); end
            end
            if (c >= 3 && c <= 8) begin
                checks++; if (bus.count !== 2'd3) begin errors++; $display("FAIL walk_count cycle %0d got %0d want 3", c, bus.count); end
            end
            step();
        end
    endtask

    task automatic test_mask();
        bus.out_ready = 1'b1; bus.in_valid = 1'b1;
        bus.in_data = {8'h5A, 8'hA5}; bus.in_mask = 2'b01;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mask_accept got %b want 1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0; bus.in_mask = 2'b10; bus.in_data = 16'hFFFF;
        for (int c = 1; c <= 5; c++) begin
            #1;
            checks++; if (bus.out_valid !== (c == 3)) begin errors++; $display("FAIL mask_valid cycle %0d got %b want %b", c, bus.out_valid, (c == 3)); end
            if (c == 3) begin
                checks++; if (bus.out_data !== 16'h00A5) begin errors++; $display("FAIL mask_data got %h want 00a5", bus.out_data); end
            end else begin
                checks++; if (bus.out_data !== 16'h0) begin errors++; $display("FAIL mask_idle_data cycle %0d got %h want 0000", c, bus.out_data); end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] q[$];
        logic [15:0] exp;
        int j = 0;
        int emitted = 0;
        int cyc = 0;
        bus.out_ready = 1'b0; bus.in_mask = 2'b11;
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = {8'(8'hB0 + j), 8'(8'hC0 + j)};
            #1;
            if (bus.in_ready) begin q.push_back(bus.in_data); j++; end
            step();
        end
        checks++; if (j != 3) begin errors++; $display("FAIL bp_accepted got %0d want 3", j); end
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", bus.in_ready); end
        checks++; if (bus.count !== 2'd3) begin errors++; $display("FAIL bp_count got %0d want 3", bus.count); end
        bus.out_ready = 1'b1;
        while (emitted < 5 && cyc < 30) begin
            bus.in_valid = (j < 5);
            bus.in_data  = {8'(8'hB0 + j), 8'(8'hC0 + j)};
            #1;
            if (bus.out_valid && bus.out_ready) begin
                exp = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
                checks++; if (bus.out_data !== exp) begin errors++; $display("FAIL bp_order beat %0d got %h want %h", emitted, bus.out_data, exp); end
                emitted++;
            end
            if (bus.in_valid && bus.in_ready) begin q.push_back(bus.in_data); j++; end
            step();
            cyc++;
        end
        checks++; if (emitted != 5 || j != 5) begin errors++; $display("FAIL bp_drain got %0d emitted %0d accepted want 5 5", emitted, j); end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] q[$];
        logic [15:0] exp;
        logic [15:0] masked;
        int emitted = 0;
        int sent = 0;
        int cyc = 0;
        // Fill the pipe, then accept and emit on the same edge.
        bus.out_ready = 1'b0; bus.in_mask = 2'b11;
        for (int c = 0; c < 3; c++) begin
            bus.in_valid = 1'b1; bus.in_data = {2{8'(8'h11 * (c + 1))}};
            step();
        end
        bus.in_data = 16'h4444; bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_in_ready got %b want 1", bus.in_ready); end
        checks++; if (bus.out_data !== 16'h1111) begin errors++; $display("FAIL full_head got %h want 1111", bus.out_data); end
        step();
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.count !== 2'd3) begin errors++; $display("FAIL full_count got %0d want 3", bus.count); end
        for (int c = 0; c < 3; c++) begin
            exp = {2{8'(8'h22 + 8'h11 * c)}};
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp) begin errors++; $display("FAIL full_drain beat %0d got %b/%h want 1/%h", c, bus.out_valid, bus.out_data, exp); end
            step();
        end
        // Random stalls against a FIFO scoreboard.
        while (emitted < 1000 && cyc < 20000) begin
            bus.in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            bus.in_data   = 16'($urandom);
            bus.in_mask   = 2'($urandom);
            bus.out_ready = ($urandom_range(0, 1) == 1);
            #1;
            checks++; if (bus.count !== 2'(q.size())) begin errors++; $display("FAIL rand_count cycle %0d got %0d want %0d", cyc, bus.count, q.size()); end
            if (!bus.out_valid) begin
                checks++; if (bus.out_data !== 16'h0) begin errors++; $display("FAIL rand_idle_data cycle %0d got %h want 0000", cyc, bus.out_data); end
            end
            if (bus.out_valid && bus.out_ready) begin
                exp = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
                checks++; if (bus.out_data !== exp) begin errors++; $display("FAIL rand_data beat %0d got %h want %h", emitted, bus.out_data, exp); end
                emitted++;
            end
            if (bus.in_valid && bus.in_ready) begin
                masked = {bus.in_data[15:8] & {8{bus.in_mask[1]}}, bus.in_data[7:0] & {8{bus.in_mask[0]}}};
                q.push_back(masked);
                sent++;
            end
            step();
            cyc++;
        end
        checks++; if (emitted != 1000 || q.size() != 0) begin errors++; $display("FAIL rand_total got %0d emitted %0d left want 1000 0", emitted, q.size()); end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.in_mask = 2'b11;
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0; bus.in_mask = 2'b11;
        for (int c = 0; c < 2; c++) begin
            bus.in_valid = 1'b1; bus.in_data = {2{8'(8'hE0 + c)}};
            step();
        end
        bus.flush = 1'b1; bus.in_data = 16'hEEEE;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b want 0", bus.in_ready); end
        step();
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.count !== 2'd0) begin errors++; $display("FAIL flush_count got %0d want 0", bus.count); end
        for (int c = 0; c < 4; c++) begin
            step();
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_leak cycle %0d got %b want 0", c, bus.out_valid); end
        end
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b1; bus.in_mask = 2'b11;
        for (int c = 0; c < 2; c++) begin
            bus.in_valid = 1'b1; bus.in_data = {2{8'(8'h30 + c)}};
            step();
        end
        step();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0 || bus.count !== 2'd0) begin
            errors++; $display("FAIL arst_outputs got %b/%h/%0d want 0/0000/0", bus.out_valid, bus.out_data, bus.count);
        end
        checks++; if ({bus.dummy_1, bus.dummy_2} !== 2'b00) begin errors++; $display("FAIL arst_dummy got %b want 00", {bus.dummy_1, bus.dummy_2}); end
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b1;
        step();
        bus.in_valid = 1'b1; bus.in_data = 16'h8080;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL arst_accept got %b want 1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            #1;
            checks++; if (bus.out_valid !== (c == 3)) begin errors++; $display("FAIL arst_latency cycle %0d got %b want %b", c, bus.out_valid, (c == 3)); end
            if (c == 3) begin
                checks++; if (bus.out_data !== 16'h8080) begin errors++; $display("FAIL arst_data got %h want 8080", bus.out_data); end
            end
            checks++; if ({bus.dummy_1, bus.dummy_2} !== 2'b00) begin errors++; $display("FAIL arst_dummy cycle %0d got %b want 00", c, {bus.dummy_1, bus.dummy_2}); end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_walking_one();
        test_mask();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
